// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for the RTC multiplexed address/data port.
// One start request runs one address phase followed by one data write or read.
module rtc_bus_ctrl #(
  parameter int PHASE_CYC = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADR_LO = 3'd1,
    ADR_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(PHASE_CYC - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic       wr_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic       phase_end;

  assign phase_end = (cnt_reg == LAST_CNT);
  assign estado    = state_reg;

  // Every output is set on the edge that enters the state it belongs to,
  // so the pins change exactly at phase boundaries.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      wr_reg    <= 1'b0;
      addr_reg  <= 8'd0;
      wdata_reg <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'd0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a_d       <= 1'b1;
      ad_out    <= 8'd0;
      ad_oe     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            wr_reg    <= wr;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            state_reg <= ADR_LO;
            cnt_reg   <= 8'd0;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            a_d       <= 1'b0;
            wr_n      <= 1'b0;
            ad_out    <= addr;
            ad_oe     <= 1'b1;
          end
        end
        ADR_LO: begin
          if (phase_end) begin
            state_reg <= ADR_HI;
            cnt_reg   <= 8'd0;
            wr_n      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ADR_HI: begin
          if (phase_end) begin
            state_reg <= DAT_LO;
            cnt_reg   <= 8'd0;
            a_d       <= 1'b1;
            if (wr_reg) begin
              wr_n   <= 1'b0;
              ad_out <= wdata_reg;
              ad_oe  <= 1'b1;
            end else begin
              rd_n   <= 1'b0;
              ad_out <= 8'd0;
              ad_oe  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DAT_LO: begin
          if (phase_end) begin
            state_reg <= DAT_HI;
            cnt_reg   <= 8'd0;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            // Capture while rd_n is still low on this edge.
            if (!wr_reg) rdata <= ad_in;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DAT_HI: begin
          if (phase_end) begin
            state_reg <= FIN;
            cnt_reg   <= 8'd0;
            cs_n      <= 1'b1;
            ad_oe     <= 1'b0;
            a_d       <= 1'b1;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: two instances (PHASE_CYC 5 and 1) share stimulus and are
// compared every cycle against a phase-offset reference model.
module tb_rtc_bus_ctrl;

  logic       clk;
  logic       clr, start, wr;
  logic [7:0] addr, wdata, ad_in;

  logic       busy_o   [2];
  logic       done_o   [2];
  logic [7:0] rdata_o  [2];
  logic       cs_n_o   [2];
  logic       rd_n_o   [2];
  logic       wr_n_o   [2];
  logic       a_d_o    [2];
  logic [7:0] ad_out_o [2];
  logic       ad_oe_o  [2];
  logic [2:0] estado_o [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      rtc_bus_ctrl #(.PHASE_CYC(gi == 0 ? 5 : 1)) dut (
        .clk(clk), .clr(clr), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
        .ad_in(ad_in), .busy(busy_o[gi]), .done(done_o[gi]), .rdata(rdata_o[gi]),
        .cs_n(cs_n_o[gi]), .rd_n(rd_n_o[gi]), .wr_n(wr_n_o[gi]), .a_d(a_d_o[gi]),
        .ad_out(ad_out_o[gi]), .ad_oe(ad_oe_o[gi]), .estado(estado_o[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pc [2] = '{5, 1};

  // Reference model: transaction progress is the cycle offset since acceptance.
  bit         m_act  [2];
  int         m_t    [2];
  logic       m_wr   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wdat [2];
  logic [7:0] m_rd   [2];
  bit         m_rst  [2];
  int         done_cnt  [2];
  int         last_done [2];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  function automatic void model_update(int i);
    int p;
    p = pc[i];
    if (clr) begin
      m_act[i] = 0;
      m_t[i]   = 0;
      m_rd[i]  = 8'd0;
      m_rst[i] = 1;
    end else if (m_act[i]) begin
      if (m_t[i] == 4 * p + 1) begin
        m_act[i] = 0;
      end else begin
        if (m_t[i] == 3 * p && !m_wr[i]) m_rd[i] = ad_in;
        m_t[i]++;
      end
    end else if (start) begin
      m_act[i]  = 1;
      m_t[i]    = 1;
      m_wr[i]   = wr;
      m_addr[i] = addr;
      m_wdat[i] = wdata;
      m_rst[i]  = 0;
    end
  endfunction

  task automatic compare(int i);
    int p, t, ph;
    logic [25:0] e, m, a;
    logic [7:0] ado;
    logic cs_e, rd_e, wr_e, ad_e, oe_e;
    p = pc[i];
    t = m_t[i];
    if (!m_act[i])       ph = 0;
    else if (t <= p)     ph = 1;
    else if (t <= 2 * p) ph = 2;
    else if (t <= 3 * p) ph = 3;
    else if (t <= 4 * p) ph = 4;
    else                 ph = 5;
    cs_e = !(ph >= 1 && ph <= 4);
    rd_e = !(ph == 3 && !m_wr[i]);
    wr_e = !(ph == 1 || (ph == 3 && m_wr[i]));
    ad_e = !(ph == 1 || ph == 2);
    oe_e = (ph == 1 || ph == 2 || ((ph == 3 || ph == 4) && m_wr[i]));
    if (ph == 1 || ph == 2)      ado = m_addr[i];
    else if (ph == 3 || ph == 4) ado = m_wr[i] ? m_wdat[i] : 8'd0;
    else                         ado = 8'd0;
    e = {ph != 0, ph == 5, m_rd[i], cs_e, rd_e, wr_e, ad_e, ado, oe_e, 3'(ph)};
    m = '1;
    if (!((ph >= 1 && ph <= 4) || m_rst[i])) m[11:4] = 8'd0;
    a = {busy_o[i], done_o[i], rdata_o[i], cs_n_o[i], rd_n_o[i], wr_n_o[i], a_d_o[i],
         ad_out_o[i], ad_oe_o[i], estado_o[i]};
    chk($sformatf("cyc%0d_p%0d outputs", cyc, p), 32'(a & m), 32'(e & m));
  endtask

  // One clock: model follows the same inputs the DUT samples, outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (done_o[i]) begin
        done_cnt[i]++;
        last_done[i] = cyc;
      end
      compare(i);
    end
  endtask

  task automatic run_txn(vec_t v);
    int k;
    wr = v.wr; addr = v.addr; wdata = v.wdata; ad_in = v.din;
    last_done[0] = -1000;
    last_done[1] = -1000;
    start = 1'b1;
    step();
    start = 1'b0;
    k = cyc - 1;
    repeat (21) step();
    chk($sformatf("txn_%h latency_p5", v.addr), 32'(last_done[0] - k), 32'd21);
    chk($sformatf("txn_%h latency_p1", v.addr), 32'(last_done[1] - k), 32'd5);
    chk($sformatf("txn_%h rdata_p5", v.addr), 32'(rdata_o[0]), 32'(v.exp_rdata));
    chk($sformatf("txn_%h rdata_p1", v.addr), 32'(rdata_o[1]), 32'(v.exp_rdata));
  endtask

  initial begin
    int k, d0;
    vecs[0] = '{1'b1, 8'h21, 8'h59, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h22, 8'h00, 8'h37, 8'h37};
    vecs[2] = '{1'b1, 8'h10, 8'hA5, 8'hFF, 8'h37};
    vecs[3] = '{1'b0, 8'h0F, 8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 8'h00, 8'hFF, 8'h5A, 8'h00};
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_wdat[i] = 0;
      m_rd[i] = 0; m_rst[i] = 1; done_cnt[i] = 0; last_done[i] = -1000;
    end
    clr = 1'b1; start = 1'b0; wr = 1'b0; addr = 8'd0; wdata = 8'd0; ad_in = 8'd0;

    // Reset, then a long idle with noise on the data inputs.
    step(); step();
    clr = 1'b0;
    chk("reset_estado", 32'(estado_o[0]), 32'd0);
    chk("reset_cs_n", 32'(cs_n_o[0]), 32'd1);
    repeat (50) begin
      wr = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
      step();
    end
    chk("idle_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
    chk("idle_cs_n", 32'(cs_n_o[0]), 32'd1);

    for (int v = 0; v < 6; v++) run_txn(vecs[v]);

    // Starts during the transaction and in FIN are dropped; the one in IDLE is taken.
    wr = 1'b0; addr = 8'h40; ad_in = 8'h6B;
    start = 1'b1;
    step();
    start = 1'b0;
    k = cyc - 1;
    d0 = done_cnt[0];
    while (cyc < k + 23) begin
      start = (cyc == k + 7) || (cyc == k + 21) || (cyc == k + 22);
      step();
    end
    start = 1'b0;
    chk("ignored_one_done", 32'(done_cnt[0] - d0), 32'd1);
    chk("ignored_accept_busy", 32'(busy_o[0]), 32'd1);
    chk("ignored_accept_estado", 32'(estado_o[0]), 32'd1);
    chk("ignored_rdata", 32'(rdata_o[0]), 32'h6B);
    repeat (22) step();

    // Reset during DAT_LO of a read.
    wr = 1'b0; addr = 8'h22; ad_in = 8'h99;
    start = 1'b1;
    step();
    start = 1'b0;
    k = cyc - 1;
    d0 = done_cnt[0];
    while (cyc < k + 12) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("midclr_cs_n", 32'(cs_n_o[0]), 32'd1);
    chk("midclr_rd_n", 32'(rd_n_o[0]), 32'd1);
    chk("midclr_ad_oe", 32'(ad_oe_o[0]), 32'd0);
    chk("midclr_busy", 32'(busy_o[0]), 32'd0);
    chk("midclr_rdata", 32'(rdata_o[0]), 32'd0);
    repeat (30) step();
    chk("midclr_no_done", 32'(done_cnt[0] - d0), 32'd0);

    // PHASE_CYC=1: write then read, starts six cycles apart.
    wr = 1'b1; addr = 8'h33; wdata = 8'h44; ad_in = 8'hA7;
    last_done[1] = -1000;
    start = 1'b1;
    step();
    start = 1'b0;
    k = cyc - 1;
    while (cyc < k + 6) step();
    chk("p1_b2b_done1", 32'(last_done[1] - k), 32'd5);
    wr = 1'b0; addr = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p1_b2b_accept", 32'(busy_o[1]), 32'd1);
    while (cyc < k + 12) step();
    chk("p1_b2b_done2", 32'(last_done[1] - k), 32'd11);
    chk("p1_b2b_rdata", 32'(rdata_o[1]), 32'hA7);
    repeat (25) step();

    // Random traffic with occasional resets.
    repeat (3000) begin
      clr   = ($urandom_range(0, 255) == 0);
      start = ($urandom_range(0, 5) == 0);
      wr    = 1'($urandom);
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      ad_in = 8'($urandom);
      step();
    end
    clr = 1'b0;
    start = 1'b0;
    repeat (25) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle engine for the RTC's multiplexed address/data port: the responder side of the `envioRCLK` request issued by the top-level `FSM` sequencer. On a one-cycle start request it drives one complete RTC register transaction (address phase, then a data write or data read) on the chip's `cs_n`/`rd_n`/`wr_n`/`a_d`/`ad` pins. It returns read data with a one-cycle `done` pulse that the sequencer uses to trigger `envioRAM`. It sits between `FSM` and the top-level RTC pins.

## Interface
- `PHASE_CYC`, default 5: clock cycles per bus phase (strobe-low or strobe-high); legal range 1..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `clr`  in  1  reset; synchronous and active-high.
- `start`  in  1  transaction request; sampled only in IDLE.
- `wr`  in  1  1 = register write, 0 = register read; latched with `start`.
- `addr`  in  8  RTC register address; latched with `start`.
- `wdata`  in  8  write data; latched with `start`.
- `ad_in`  in  8  RTC bus input (tristate buffer read side).
- `busy`  out  1  high from the cycle after acceptance through the FIN cycle.
- `done`  out  1  one-cycle pulse in FIN.
- `rdata`  out  8  last read data; holds until the next read completes.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  RTC strobes, active-low.
- `a_d`  out  1  0 = address phase, 1 = data phase.
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  tristate enable for `ad_out`.
- `estado`  out  3  state code, for debug and simulation.

## Operation
- All outputs are registered. Reset values: `cs_n`=1, `rd_n`=1, `wr_n`=1, `a_d`=1, `ad_out`=0, `ad_oe`=0, `busy`=0, `done`=0, `rdata`=0, `estado`=IDLE.
- State codes: IDLE=0, ADR_LO=1, ADR_HI=2, DAT_LO=3, DAT_HI=4, FIN=5.
- IDLE:
  - Idle values are `cs_n`=`rd_n`=`wr_n`=1, `a_d`=1, `ad_oe`=0.
  - If `start`=1: latch `wr`, `addr`, `wdata`; go to ADR_LO.
- ADR_LO, PHASE_CYC cycles: `cs_n`=0, `a_d`=0, `wr_n`=0, `ad_out`=addr, `ad_oe`=1.
- ADR_HI, PHASE_CYC cycles: `wr_n`=1; `cs_n`, `a_d`, `ad_out` and `ad_oe` hold their ADR_LO values (address hold).
- DAT_LO, PHASE_CYC cycles: `a_d`=1, `cs_n`=0.
  - Write: `wr_n`=0, `ad_out`=wdata, `ad_oe`=1.
  - Read: `rd_n`=0, `ad_oe`=0, `ad_out`=0.
- DAT_HI, PHASE_CYC cycles:
  - `wr_n`=`rd_n`=1; `cs_n` stays 0.
  - On a write, `ad_oe` stays 1 (data hold).
  - On a read, `rdata` is loaded from `ad_in` on the edge that leaves DAT_LO.
- FIN, 1 cycle: `cs_n`=1, `ad_oe`=0, `a_d`=1, `done`=1. Always returns to IDLE.
- Phase counter: 8-bit. Cleared on every state entry. The state advances when counter = PHASE_CYC-1.
- `start` outside IDLE, including during FIN, is ignored and not queued.
- `rdata` is untouched by write transactions.
- `clr` mid-transaction: on the next edge every output takes its reset value, including `rdata`=0. The strobes release immediately, no `done` is issued, and the latched request is discarded.
- `clr` and `start` both high: `clr` wins.

## Timing
- `start` sampled high at edge k (state IDLE):
  - ADR_LO occupies cycles k+1 .. k+P, where P = PHASE_CYC.
  - ADR_HI occupies k+P+1 .. k+2P.
  - DAT_LO occupies k+2P+1 .. k+3P.
  - DAT_HI occupies k+3P+1 .. k+4P.
  - FIN is cycle k+4P+1.
- Latency from `start` to `done` is 4P+1 cycles: 21 cycles at P=5.
- `busy` is 1 for exactly 4P+1 cycles.
- Back-to-back transactions: minimum spacing between accepted `start`s is 4P+2 cycles, because there is one mandatory IDLE cycle after FIN.
- `rdata` is valid from the first DAT_HI cycle and is stable when `done` rises.
- Bus ordering: `a_d` changes only while `wr_n`=`rd_n`=1, and `ad_oe` never drops while `wr_n`=0.

## Test plan
- Reset, then idle: `clr`=1 for 2 cycles, then 0 → all outputs at reset values; `estado`=0; no strobe activity for 50 cycles.
- Write, P=5: `start`, `wr`=1, `addr`=0x21, `wdata`=0x59 →
  - `cs_n` low for cycles k+1..k+20, with `a_d`=0 and `ad_out`=0x21 during k+1..k+10;
  - `wr_n` low during k+1..k+5 and k+11..k+15, with `ad_out`=0x59 during k+11..k+20;
  - `done` at k+21; `rdata` stays 0.
- Read: the model drives `ad_in`=0x37 while `rd_n`=0; `start`, `wr`=0, `addr`=0x22 → `rd_n` low k+11..k+15, `ad_oe`=0 throughout the data phases, `rdata`=0x37 from k+16, `done` at k+21.
- Ignored request: pulse `start` at k+7 and again in the FIN cycle → exactly one transaction and one `done`; a new `start` in IDLE at k+22 is accepted.
- Reset mid-cycle: assert `clr` at k+12 (DAT_LO of a read) → at k+13 `cs_n`=`rd_n`=1, `ad_oe`=0, `busy`=0, `rdata`=0; `done` never pulses.
- PHASE_CYC=1: write then read back-to-back → `done` at k+5 each time; accepted `start`s are 6 cycles apart.
